multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  Control unit for the multi-cycle MIPS-subset CPU that succeeds the single-cycle datapath.
//  Moore FSM sequences each instruction over 3-5 cycles, driving the shared ALU, IR/MDR and memory-port enables.
//  Stretches any memory step until the memory acknowledges, with a parametrised timeout.
//  Traps on illegal opcode or timeout and counts retired instructions.
// PARAMETERS
//  TIMEOUT  16  max wait cycles per memory step before trapping (>=1)
//  CNT_W    32  width of retired-instruction counter
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      reset, asynchronous, active-high
//  opcode_i       in   6      IR[31:26], stable from DECODE onward
//  mem_ack_i      in   1      memory done; read data valid / write accepted this cycle
//  mem_req_o      out  1      memory access request
//  mem_we_o       out  1      1=write, 0=read (valid with mem_req_o)
//  iord_o         out  1      memory address: 0=PC, 1=ALUOut
//  ir_write_o     out  1      load IR from memory data
//  mdr_write_o    out  1      load MDR from memory data
//  pc_write_o     out  1      unconditional PC load
//  pc_write_cond_o out 1      PC load if branch condition true
//  branch_ne_o    out  1      branch condition: 0=zero, 1=!zero
//  pc_source_o    out  2      0=ALU result, 1=ALUOut, 2=jump target
//  alu_src_a_o    out  1      ALU A: 0=PC, 1=rs
//  alu_src_b_o    out  2      ALU B: 0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  alu_op_o       out  3      0=add, 1=sub, 2=R-type (funct), 3=slt
//  reg_dst_o      out  1      write reg: 0=rt, 1=rd
//  mem_to_reg_o   out  1      write data: 0=ALUOut, 1=MDR
//  reg_write_o    out  1      register file write enable
//  retire_o       out  1      one-cycle pulse per completed instruction
//  instr_cnt_o    out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
//  trap_o         out  1      sticky trap flag
//  trap_code_o    out  2      0=none, 1=illegal opcode, 2=memory timeout
// BEHAVIOUR
//  Opcodes: R=000000 addi=001000 slti=001010 lw=100011 sw=101011 beq=000100 bne=000101 j=000010.
//  Reset (async): state=FETCH, wait counter=0, instr_cnt_o=0, trap_o=0, trap_code_o=0, retire_o=0.
//   While rst_i=1, every write enable (ir/mdr/pc/pc_cond/reg_write) and mem_req_o is forced to 0.
//  States and transitions:
//   FETCH:    mem_req=1, iord=0, srcA=0, srcB=1, alu_op=add, pc_source=0.
//             On ack: ir_write=1, pc_write=1 (PC+4), go to DECODE.
//   DECODE:   srcA=0, srcB=3, alu_op=add (branch target into ALUOut).
//             Next: lw/sw->MEM_ADDR, R->R_EXEC, addi/slti->I_EXEC, beq/bne->BRANCH, j->JUMP, else->TRAP(code 1).
//   MEM_ADDR: srcA=1, srcB=2, add; lw->MEM_RD, sw->MEM_WR.
//   MEM_RD:   mem_req=1, iord=1, we=0; on ack mdr_write=1 -> MEM_WB.
//   MEM_WB:   reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH (retire).
//   MEM_WR:   mem_req=1, iord=1, we=1; on ack -> FETCH (retire).
//   R_EXEC:   srcA=1, srcB=0, alu_op=R -> R_WB.
//   R_WB:     reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH (retire).
//   I_EXEC:   srcA=1, srcB=2, alu_op=add (addi) or slt (slti) -> I_WB.
//   I_WB:     reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH (retire).
//   BRANCH:   srcA=1, srcB=0, sub, pc_write_cond=1, pc_source=1, branch_ne=(op==bne) -> FETCH (retire).
//   JUMP:     pc_write=1, pc_source=2 -> FETCH (retire).
//   TRAP:     absorbing; all enables 0, mem_req=0; exited only by reset.
//  Outputs not listed for a state are 0. Outputs are decoded from state only,
//   except ir/pc/mdr write in FETCH/MEM_RD, which are qualified by mem_ack_i.
//  Wait counter: counts cycles in memory states without ack and clears on ack or state change.
//   Reaching TIMEOUT with no ack -> TRAP, code 2. Ack on the same cycle the count reaches TIMEOUT wins; no trap.
//  Retire: retire_o pulses 1 cycle on each transition into FETCH from a terminal state; instr_cnt_o increments
//   the following edge; wraps all-ones -> 0. An instruction aborted to TRAP does not retire.
//  Cycle counts with ack on first cycle: lw 5, sw 4, R/addi/slti 4, beq/bne/j 3.
// TESTING
//  Reset then add (R) with immediate acks -> 4 cycles, reg_dst=1 and reg_write=1 in cycle 4, retire_o pulse, instr_cnt_o=1.
//  lw with mem_ack_i delayed 3 cycles in MEM_RD -> mdr_write_o only on the ack cycle, total 8 cycles, then reg_write with mem_to_reg=1.
//  beq then bne -> pc_write_cond=1 and pc_source=1 in cycle 3; branch_ne_o 0 then 1; j -> pc_write=1, pc_source=2.
//  Opcode 111111 -> TRAP after DECODE, trap_code_o=1, no further mem_req_o; rst_i pulse mid-TRAP -> FETCH, count 0.
//  TIMEOUT=4, no ack in FETCH -> TRAP code 2 after 4 wait cycles; ack exactly on 4th cycle -> no trap.
//  CNT_W=4, 16 retired instructions -> instr_cnt_o wraps 15 -> 0; async reset asserted mid-MEM_WR drops mem_req_o at once.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit.
// A Moore FSM steps each instruction through 3-5 states. It drives the shared
// ALU, the IR/MDR/PC load enables and the memory port. Memory steps are
// stretched until acknowledged, bounded by a timeout. The unit traps on an
// illegal opcode or a memory timeout and counts retired instructions.
//
// Memory handshake: mem_req_o is held high for the whole memory step and the
// request is complete on the first cycle where mem_ack_i is high. That cycle is
// the only one in which read data is captured (ir_write_o / mdr_write_o) or a
// write is considered accepted. The FSM leaves the memory state on the
// following edge, so mem_req_o drops unless the next state also requests.
module multi_cycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             mdr_write_o,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             branch_ne_o,
  output logic [1:0]       pc_source_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic             trap_o,
  output logic [1:0]       trap_code_o,
  output logic [3:0]       state_dbg_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_mem;
  logic              wait_hit;
  logic              enter_trap;
  logic [1:0]        trap_cause;
  logic              retire_nxt;

  assign state_dbg_o = state;

  // Next state, plus the trap/retire events that the transition implies.
  always_comb begin
    state_nxt  = state;
    in_mem     = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // This is the last permitted wait cycle; no ack here means a timeout.
    wait_hit   = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    unique case (state)
      S_FETCH: begin
        if (mem_ack_i)     state_nxt = S_DECODE;
        else if (wait_hit) state_nxt = S_TRAP;
      end
      S_DECODE: begin
        unique case (opcode_i)
          OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
          OP_R:             state_nxt = S_R_EXEC;
          OP_ADDI, OP_SLTI: state_nxt = S_I_EXEC;
          OP_BEQ, OP_BNE:   state_nxt = S_BRANCH;
          OP_J:             state_nxt = S_JUMP;
          default:          state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_nxt = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ack_i)     state_nxt = S_MEM_WB;
        else if (wait_hit) state_nxt = S_TRAP;
      end
      S_MEM_WB: state_nxt = S_FETCH;
      S_MEM_WR: begin
        if (mem_ack_i)     state_nxt = S_FETCH;
        else if (wait_hit) state_nxt = S_TRAP;
      end
      S_R_EXEC: state_nxt = S_R_WB;
      S_R_WB:   state_nxt = S_FETCH;
      S_I_EXEC: state_nxt = S_I_WB;
      S_I_WB:   state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_TRAP;
    endcase
    enter_trap = (state != S_TRAP) && (state_nxt == S_TRAP);
    // DECODE only traps on a bad opcode; every other trap source is a memory wait.
    trap_cause = (state == S_DECODE) ? 2'd1 : 2'd2;
    // Only terminal states move into FETCH from elsewhere.
    retire_nxt = (state != S_FETCH) && (state_nxt == S_FETCH);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Wait counter: advances only while a memory state is stalled, else clears.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      wait_cnt <= '0;
    else if (in_mem && !mem_ack_i && (state_nxt == state))
      wait_cnt <= wait_cnt + WAIT_W'(1);
    else
      wait_cnt <= '0;
  end

  // Retire pulse, retired-instruction counter and sticky trap status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retire_o    <= 1'b0;
      instr_cnt_o <= '0;
      trap_o      <= 1'b0;
      trap_code_o <= 2'd0;
    end else begin
      retire_o    <= retire_nxt;
      instr_cnt_o <= instr_cnt_o + CNT_W'(retire_o);
      if (enter_trap) begin
        trap_o      <= 1'b1;
        trap_code_o <= trap_cause;
      end
    end
  end

  // Control outputs decoded from state; memory captures are qualified by ack.
  always_comb begin
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    iord_o          = 1'b0;
    ir_write_o      = 1'b0;
    mdr_write_o     = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_ne_o     = 1'b0;
    pc_source_o     = 2'd0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'd0;
    alu_op_o        = 3'd0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'd1;
        ir_write_o  = mem_ack_i;
        pc_write_o  = mem_ack_i;
      end
      S_DECODE:   alu_src_b_o = 2'd3;
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
      end
      S_MEM_RD: begin
        mem_req_o   = 1'b1;
        iord_o      = 1'b1;
        mdr_write_o = mem_ack_i;
      end
      S_MEM_WB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'd2;
      end
      S_R_WB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o    = (opcode_i == OP_SLTI) ? 3'd3 : 3'd0;
      end
      S_I_WB: reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = 3'd1;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 2'd1;
        branch_ne_o     = (opcode_i == OP_BNE);
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'd2;
      end
      default: ;
    endcase
    // Reset lands in FETCH, which would otherwise request memory; hold
    // everything with a side effect quiet while reset is asserted.
    if (rst_i) begin
      mem_req_o       = 1'b0;
      ir_write_o      = 1'b0;
      mdr_write_o     = 1'b0;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      reg_write_o     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Testbench for multi_cycle_ctrl (TIMEOUT=4, CNT_W=4).
// Instructions are described by opcode and memory-wait lengths. The bench
// expands each one into the cycle-by-cycle control words it must produce and
// queues them. A compare process checks every queued cycle on the falling
// edge. Literal checks pin cycle counts, the counter and the trap codes.
module tb_multi_cycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;
  localparam int WW = 27;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef enum int {
    PH_FETCH, PH_DECODE, PH_MEM_ADDR, PH_MEM_RD, PH_MEM_WB, PH_MEM_WR,
    PH_R_EXEC, PH_R_WB, PH_I_EXEC, PH_I_WB, PH_BRANCH, PH_JUMP, PH_TRAP
  } phase_e;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic          mem_ack;
  logic          mem_req_o, mem_we_o, iord_o, ir_write_o, mdr_write_o;
  logic          pc_write_o, pc_write_cond_o, branch_ne_o;
  logic [1:0]    pc_source_o, alu_src_b_o, trap_code_o;
  logic          alu_src_a_o, reg_dst_o, mem_to_reg_o, reg_write_o;
  logic [2:0]    alu_op_o;
  logic          retire_o, trap_o;
  logic [CW-1:0] instr_cnt_o;
  logic [3:0]    state_dbg_o;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ack_i(mem_ack),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o),
    .ir_write_o(ir_write_o), .mdr_write_o(mdr_write_o), .pc_write_o(pc_write_o),
    .pc_write_cond_o(pc_write_cond_o), .branch_ne_o(branch_ne_o),
    .pc_source_o(pc_source_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o(reg_write_o), .retire_o(retire_o), .instr_cnt_o(instr_cnt_o),
    .trap_o(trap_o), .trap_code_o(trap_code_o), .state_dbg_o(state_dbg_o)
  );

  // ---------------- model state ----------------
  int            errors = 0;
  int            checks = 0;
  int            ncyc   = 0;
  int            cyc_no = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] cmp_exp, cmp_act;
  logic [CW-1:0] m_cnt    = '0;
  bit            m_retire = 1'b0;
  bit            m_trap   = 1'b0;
  logic [1:0]    m_code   = 2'd0;

  // Expected control word for one cycle of a given instruction step.
  function automatic logic [WW-1:0] model_word(input phase_e p, input logic [5:0] op,
                                               input logic ack);
    logic req = 0, we = 0, iord = 0, irw = 0, mdrw = 0, pcw = 0, pcc = 0, bne = 0;
    logic sa = 0, rd = 0, m2r = 0, rw = 0;
    logic [1:0] pcs = 0, sb = 0;
    logic [2:0] aop = 0;
    case (p)
      PH_FETCH:    begin req = 1; sb = 1; irw = ack; pcw = ack; end
      PH_DECODE:   sb = 3;
      PH_MEM_ADDR: begin sa = 1; sb = 2; end
      PH_MEM_RD:   begin req = 1; iord = 1; mdrw = ack; end
      PH_MEM_WB:   begin m2r = 1; rw = 1; end
      PH_MEM_WR:   begin req = 1; we = 1; iord = 1; end
      PH_R_EXEC:   begin sa = 1; aop = 2; end
      PH_R_WB:     begin rd = 1; rw = 1; end
      PH_I_EXEC:   begin sa = 1; sb = 2; aop = (op == OP_SLTI) ? 3'd3 : 3'd0; end
      PH_I_WB:     rw = 1;
      PH_BRANCH:   begin sa = 1; aop = 1; pcc = 1; pcs = 1; bne = (op == OP_BNE); end
      PH_JUMP:     begin pcw = 1; pcs = 2; end
      default:     ;
    endcase
    return {req, we, iord, irw, mdrw, pcw, pcc, bne, pcs, sa, sb, aop, rd, m2r, rw,
            m_retire, m_trap, m_code, m_cnt};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    cyc_no++;
    if (exp_q.size() != 0) begin
      cmp_exp = exp_q.pop_front();
      cmp_act = {mem_req_o, mem_we_o, iord_o, ir_write_o, mdr_write_o, pc_write_o,
                 pc_write_cond_o, branch_ne_o, pc_source_o, alu_src_a_o, alu_src_b_o,
                 alu_op_o, reg_dst_o, mem_to_reg_o, reg_write_o, retire_o, trap_o,
                 trap_code_o, instr_cnt_o};
      checks++;
      if (cmp_act !== cmp_exp) begin
        errors++;
        $display("FAIL ctrl cycle=%0d state=%0d actual=%h expected=%h",
                 cyc_no, state_dbg_o, cmp_act, cmp_exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle (called at posedge+1) and queue its expected outputs.
  task automatic emit(input phase_e p, input logic [5:0] op, input logic ack, input bit fin);
    opcode  = op;
    mem_ack = ack;
    exp_q.push_back(model_word(p, op, ack));
    ncyc++;
    @(posedge clk); #1;
    if (m_retire) m_cnt = m_cnt + 1'b1;
    m_retire = fin;
  endtask

  // A memory step with d ack-less cycles; d >= TO means it must time out.
  task automatic mem_phase(input phase_e p, input logic [5:0] op, input int d,
                           input bit fin, output bit ok);
    for (int i = 0; i < d && i < TO; i++) emit(p, op, 1'b0, 1'b0);
    if (d >= TO) begin
      m_trap = 1'b1;
      m_code = 2'd2;
      ok     = 1'b0;
    end else begin
      emit(p, op, 1'b1, fin);
      ok = 1'b1;
    end
  endtask

  // Whole instruction: d_fetch / d_mem are wait cycles before each ack.
  task automatic run_instr(input logic [5:0] op, input int d_fetch, input int d_mem);
    bit ok;
    ncyc = 0;
    mem_phase(PH_FETCH, op, d_fetch, 1'b0, ok);
    if (ok) begin
      emit(PH_DECODE, op, 1'b0, 1'b0);
      case (op)
        OP_LW: begin
          emit(PH_MEM_ADDR, op, 1'b0, 1'b0);
          mem_phase(PH_MEM_RD, op, d_mem, 1'b0, ok);
          if (ok) emit(PH_MEM_WB, op, 1'b0, 1'b1);
        end
        OP_SW: begin
          emit(PH_MEM_ADDR, op, 1'b0, 1'b0);
          mem_phase(PH_MEM_WR, op, d_mem, 1'b1, ok);
        end
        OP_R: begin
          emit(PH_R_EXEC, op, 1'b0, 1'b0);
          emit(PH_R_WB, op, 1'b0, 1'b1);
        end
        OP_ADDI, OP_SLTI: begin
          emit(PH_I_EXEC, op, 1'b0, 1'b0);
          emit(PH_I_WB, op, 1'b0, 1'b1);
        end
        OP_BEQ, OP_BNE: emit(PH_BRANCH, op, 1'b0, 1'b1);
        OP_J:           emit(PH_JUMP, op, 1'b0, 1'b1);
        default: begin
          m_trap = 1'b1;
          m_code = 2'd1;
        end
      endcase
    end
  endtask

  // Assert reset mid-cycle (ack held high so ungated enables would show),
  // check the forced/reset values, then release after the next edge.
  task automatic do_reset();
    rst     = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("rst_enables_low", 32'({mem_req_o, ir_write_o, mdr_write_o, pc_write_o,
                                pc_write_cond_o, reg_write_o}), 32'd0);
    chk("rst_instr_cnt", 32'(instr_cnt_o), 32'd0);
    chk("rst_trap", 32'(trap_o), 32'd0);
    chk("rst_trap_code", 32'(trap_code_o), 32'd0);
    chk("rst_retire", 32'(retire_o), 32'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    mem_ack  = 1'b0;
    m_cnt    = '0;
    m_retire = 1'b0;
    m_trap   = 1'b0;
    m_code   = 2'd0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst     = 1'b0;
    opcode  = OP_R;
    mem_ack = 1'b0;
    #2;
    do_reset();

    // add: 4 cycles, retire pulse then counter steps to 1
    run_instr(OP_R, 0, 0);
    chk("add_cycles", 32'(ncyc), 32'd4);
    chk("add_retire", 32'(retire_o), 32'd1);
    chk("add_cnt_before_step", 32'(instr_cnt_o), 32'd0);

    // lw with 3 wait cycles in MEM_RD: 8 cycles
    run_instr(OP_LW, 0, 3);
    chk("lw_wait_cycles", 32'(ncyc), 32'd8);
    chk("cnt_after_add", 32'(instr_cnt_o), 32'd1);

    // branches and jump: 3 cycles each
    run_instr(OP_BEQ, 0, 0);
    chk("beq_cycles", 32'(ncyc), 32'd3);
    run_instr(OP_BNE, 0, 0);
    run_instr(OP_J, 0, 0);
    chk("j_cycles", 32'(ncyc), 32'd3);

    // sw with waits in both memory steps, then immediates
    run_instr(OP_SW, 1, 2);
    chk("sw_wait_cycles", 32'(ncyc), 32'd7);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_SLTI, 2, 0);
    chk("slti_cycles", 32'(ncyc), 32'd6);
    chk("cnt_after_seven", 32'(instr_cnt_o), 32'd7);

    // ack on the last permitted wait cycle wins over the timeout
    run_instr(OP_R, TO - 1, 0);
    chk("late_ack_cycles", 32'(ncyc), 32'd7);
    chk("late_ack_no_trap", 32'(trap_o), 32'd0);

    // no ack at all in FETCH: trap code 2 after TO wait cycles
    run_instr(OP_R, TO, 0);
    chk("timeout_cycles", 32'(ncyc), 32'd4);
    chk("timeout_trap", 32'(trap_o), 32'd1);
    chk("timeout_code", 32'(trap_code_o), 32'd2);
    repeat (3) emit(PH_TRAP, OP_R, 1'b1, 1'b0);
    #2;
    do_reset();

    // illegal opcode: trap code 1 after DECODE, no further requests
    run_instr(OP_BAD, 0, 0);
    chk("illegal_cycles", 32'(ncyc), 32'd2);
    chk("illegal_code", 32'(trap_code_o), 32'd1);
    repeat (3) emit(PH_TRAP, OP_LW, 1'b1, 1'b0);
    #2;
    do_reset();

    // 16 retirements on a 4-bit counter: 15 -> 0
    repeat (16) run_instr(OP_J, 0, 0);
    chk("wrap_retire", 32'(retire_o), 32'd1);
    chk("wrap_cnt_15", 32'(instr_cnt_o), 32'd15);
    emit(PH_FETCH, OP_SW, 1'b1, 1'b0);
    chk("wrap_cnt_0", 32'(instr_cnt_o), 32'd0);

    // reset asserted mid-MEM_WR drops the request immediately
    emit(PH_DECODE, OP_SW, 1'b0, 1'b0);
    emit(PH_MEM_ADDR, OP_SW, 1'b0, 1'b0);
    opcode  = OP_SW;
    mem_ack = 1'b0;
    #2;
    chk("memwr_req_before_rst", 32'({mem_req_o, mem_we_o}), 32'd3);
    do_reset();

    // clean instruction after the abort
    run_instr(OP_ADDI, 0, 0);
    chk("addi_after_rst_cycles", 32'(ncyc), 32'd4);
    chk("addi_after_rst_retire", 32'(retire_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
